// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 frame receiver: state encoding, frame geometry
// and the default inter-edge timeout.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2State_t;

    localparam int FRAME_BITS             = 11;
    localparam int DATA_BITS              = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 5000;

    // Odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic oddParityOk(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// Counts clock cycles since the last PS/2 clock edge; expired marks the cycle in
// which the count is about to reach TIMEOUT_CYCLES-1.
module ps2_timeout_counter
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
    localparam logic [CW-1:0] LAST_BEFORE_LIMIT = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // A clear in the same cycle suppresses expiry, so a late edge always wins.
    assign expired = enable && !clear && (count == LAST_BEFORE_LIMIT);

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity,
// stop. Accepted bytes are held on dataOut until acknowledged.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2ClockFallingEdge,
    input  logic       ps2Data,
    output logic [7:0] dataOut,
    output logic       dataValid,
    input  logic       dataAcknowledge,
    output logic       busy,
    output logic       parityError,
    output logic       frameError,
    output logic       overrun,
    output ps2State_t  debugState
);

    ps2State_t  state, stateNext;
    logic [2:0] bitCount, bitCountNext;
    logic [7:0] shiftReg, shiftNext;
    logic       parityBit, parityNext;
    logic [7:0] dataOutNext;
    logic       validNext;
    logic       parityErrNext, frameErrNext, overrunNext;
    logic       timeoutExpired;

    ps2_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) timeoutCounter (
        .clock  (clock),
        .reset  (reset),
        .clear  (ps2ClockFallingEdge || (state == IDLE)),
        .enable (state != IDLE),
        .expired(timeoutExpired)
    );

    // Output handshake: dataValid=1 means dataOut holds an unconsumed byte; the
    // consumer takes it by raising dataAcknowledge in any cycle with dataValid=1,
    // and dataValid drops the next cycle unless a new byte is accepted that cycle.
    always_comb begin
        stateNext     = state;
        bitCountNext  = bitCount;
        shiftNext     = shiftReg;
        parityNext    = parityBit;
        dataOutNext   = dataOut;
        validNext     = dataValid && !dataAcknowledge;
        parityErrNext = 1'b0;
        frameErrNext  = 1'b0;
        overrunNext   = 1'b0;

        case (state)
            IDLE: begin
                if (ps2ClockFallingEdge && !ps2Data) begin
                    stateNext    = DATA;
                    bitCountNext = '0;
                end
            end
            DATA: begin
                if (ps2ClockFallingEdge) begin
                    shiftNext    = {ps2Data, shiftReg[7:1]};
                    bitCountNext = bitCount + 3'd1;
                    if (bitCount == 3'(DATA_BITS - 1)) stateNext = PARITY;
                end else if (timeoutExpired) begin
                    stateNext    = IDLE;
                    frameErrNext = 1'b1;
                end
            end
            PARITY: begin
                if (ps2ClockFallingEdge) begin
                    parityNext = ps2Data;
                    stateNext  = STOP;
                end else if (timeoutExpired) begin
                    stateNext    = IDLE;
                    frameErrNext = 1'b1;
                end
            end
            STOP: begin
                if (ps2ClockFallingEdge) begin
                    stateNext = IDLE;
                    if (!ps2Data) begin
                        frameErrNext = 1'b1;
                    end else if (!oddParityOk(shiftReg, parityBit)) begin
                        parityErrNext = 1'b1;
                    end else if (dataValid && !dataAcknowledge) begin
                        overrunNext = 1'b1;
                    end else begin
                        dataOutNext = shiftReg;
                        validNext   = 1'b1;
                    end
                end else if (timeoutExpired) begin
                    stateNext    = IDLE;
                    frameErrNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            bitCount    <= '0;
            shiftReg    <= '0;
            parityBit   <= 1'b0;
            dataOut     <= 8'h00;
            dataValid   <= 1'b0;
            busy        <= 1'b0;
            parityError <= 1'b0;
            frameError  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= stateNext;
            bitCount    <= bitCountNext;
            shiftReg    <= shiftNext;
            parityBit   <= parityNext;
            dataOut     <= dataOutNext;
            dataValid   <= validNext;
            busy        <= (stateNext != IDLE);
            parityError <= parityErrNext;
            frameError  <= frameErrNext;
            overrun     <= overrunNext;
        end
    end

    assign debugState = state;

endmodule

// File: doc/ps2_frame_receiver.md
PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset named reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 5000: clock cycles allowed between PS/2 clock falling edges inside a frame.
REQ-003 Port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset; sampled on rising clock edge.
REQ-005 Port ps2ClockFallingEdge  input  1  one-cycle strobe from the upstream synchronous edge detector on the synchronized PS/2 clock.
REQ-006 Port ps2Data  input  1  synchronized PS/2 data line.
REQ-007 Port dataOut  output  8  last accepted frame byte.
REQ-008 Port dataValid  output  1  dataOut holds an unconsumed byte.
REQ-009 Port dataAcknowledge  input  1  consumer takes the byte in any cycle where dataValid=1.
REQ-010 Port busy  output  1  frame reception in progress (state not IDLE).
REQ-011 Port parityError  output  1  one-cycle strobe: frame dropped, parity wrong.
REQ-012 Port frameError  output  1  one-cycle strobe: frame dropped, bad stop bit or timeout.
REQ-013 Port overrun  output  1  one-cycle strobe: valid frame dropped, previous byte still unconsumed.

Function
REQ-014 FSM states: IDLE, DATA, PARITY, STOP. Bits are sampled only in cycles with ps2ClockFallingEdge=1.
REQ-015 IDLE: sampled ps2Data=0 (start bit) -> DATA with bit count 0. Sampled 1 -> stay IDLE, no error.
REQ-016 DATA: shift sampled bit in LSB first. After the 8th bit -> PARITY.
REQ-017 PARITY: store bit -> STOP. Parity is odd: the 8 data bits plus the parity bit SHALL contain an odd number of ones.
REQ-018 STOP: sampled bit -> IDLE. Check order: stop=0 -> frameError; else parity wrong -> parityError; else dataValid=1 and no acknowledge that cycle -> overrun; else accept.
REQ-019 Accept: dataOut and dataValid=1 update in the cycle after the stop-bit edge (latency 1 clock).
REQ-020 Error and overrun strobes SHALL be high for exactly the one cycle after the stop-bit edge. An overrun leaves dataOut unchanged.
REQ-021 dataValid SHALL stay high until the cycle after dataAcknowledge=1. If acknowledge coincides with an accept, the new byte is loaded and dataValid stays 1.
REQ-022 dataAcknowledge while dataValid=0 SHALL be ignored.
REQ-023 Timeout counter: cleared on every ps2ClockFallingEdge and in IDLE, incremented otherwise.
REQ-024 Timeout: on reaching TIMEOUT_CYCLES-1 outside IDLE -> IDLE, frameError strobe, partial frame discarded.
REQ-025 If an edge coincides with timeout, the edge SHALL win and no timeout occurs.
REQ-026 busy = (state != IDLE), registered.

Reset
REQ-027 When reset=0 at a rising clock edge, the block SHALL set: state IDLE, dataOut=8'h00, dataValid=0, busy=0, all strobes 0, counters 0.
REQ-028 Reset mid-frame SHALL discard the partial frame and emit no strobe.
REQ-029 Reset SHALL override all other inputs in the same cycle.

Structure
REQ-030 State encoding, the frame bit count (11) and the default TIMEOUT_CYCLES SHALL live in the shared package ps2_pkg.
REQ-031 The timeout counter SHALL be a sub-module, ps2_timeout_counter, with ports clear, enable and expired.
REQ-032 The block SHALL have no combinational path from inputs to outputs.

Verification
REQ-033 Byte 0x1C, bits 0,0,0,1,1,1,0,0,0,0,1 (start, LSB first, parity 0, stop): dataOut=0x1C, dataValid=1 one cycle after the last edge, no strobes.
REQ-034 Byte 0xF0 with parity 0 (wrong): parityError pulses one cycle, dataValid stays 0, dataOut unchanged.
REQ-035 Frame 0x1C sent, not acknowledged, then 0xF0 with parity 1 sent: overrun pulses, dataOut remains 0x1C. Acknowledge then clears dataValid next cycle.
REQ-036 Start bit plus 3 data bits, then no edges: frameError pulses exactly TIMEOUT_CYCLES-1 cycles after the last edge, busy=0 afterwards.
REQ-037 Stop bit 0 on an otherwise valid 0x55 frame: frameError pulses, dataValid stays 0.
REQ-038 reset=0 asserted after the 5th data bit, then a full 0x1C frame: only 0x1C is received, no strobes.
